// File: rtl/halfband_pkg.sv
// rtl/halfband_pkg.sv - shared constants, types and round/saturate helper for the halfband FIR
`ifndef HALFBAND_PKG_SV
`define HALFBAND_PKG_SV

`define HB_SAMPLE_VEC(n) logic [(n)-1:0][15:0]

package halfband_pkg;
    localparam int SW            = 16;
    localparam int HB_CWIDTH_DEF = 18;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } dec_phase_e;

    typedef struct packed {
        logic v;
        logic dec;
        logic ph;
    } ctl_t;

    // Round half up at the Q1.(cw-1) point, then clamp to the 16-bit sample range.
    function automatic logic signed [SW-1:0] round_sat(input logic signed [63:0] acc, input int cw);
        logic signed [63:0] r;
        r = (acc + (64'sd1 <<< (cw - 2))) >>> (cw - 1);
        if (r > 64'sd32767)
            return 16'sh7fff;
        else if (r < -64'sd32768)
            return 16'sh8000;
        return r[SW-1:0];
    endfunction
endpackage

`endif

// File: rtl/halfband_lane.sv
// rtl/halfband_lane.sv - one output sample: pre-add, multiply, adder tree with round/saturate
module halfband_lane
    import halfband_pkg::*;
#(
    parameter int NCOEF  = 3,
    parameter int CWIDTH = HB_CWIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NCOEF-2:0][SW-1:0]    win,
    input  logic [NCOEF-1:0][CWIDTH-1:0]  coef,
    output logic [SW-1:0]                 y
);
    localparam int D    = 2*NCOEF - 1;
    localparam int PW   = SW + CWIDTH + 1;
    localparam int ACCW = SW + CWIDTH + $clog2(2*NCOEF + 1);

    logic [NCOEF-1:0][SW:0]   pre_s1;
    logic [SW-1:0]            ctr_s1;
    logic [NCOEF-1:0][PW-1:0] prod_s2;
    logic [ACCW-1:0]          ctr_s2;
    logic signed [ACCW-1:0]   acc;
    logic                     unused_win;

    // Even-offset taps are structurally zero; only the centre and odd offsets are read.
    assign unused_win = ^win;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_s1  <= '0;
            ctr_s1  <= '0;
            prod_s2 <= '0;
            ctr_s2  <= '0;
        end else begin
            ctr_s1 <= win[D];
            for (int k = 0; k < NCOEF; k++)
                pre_s1[k] <= {win[D-2*k-1][SW-1], win[D-2*k-1]} + {win[D+2*k+1][SW-1], win[D+2*k+1]};
            ctr_s2 <= ACCW'($signed(ctr_s1)) <<< (CWIDTH - 2);
            for (int k = 0; k < NCOEF; k++)
                prod_s2[k] <= PW'($signed(pre_s1[k])) * PW'($signed(coef[k]));
        end
    end

    always_comb begin
        acc = $signed(ctr_s2);
        for (int k = 0; k < NCOEF; k++)
            acc = acc + ACCW'($signed(prod_s2[k]));
    end

    assign y = round_sat(64'(acc), CWIDTH);
endmodule

// File: rtl/halfband_mp.sv
// rtl/halfband_mp.sv - multi-sample-per-clock halfband FIR with double-buffered coefficients and decimate-by-2 packing
module halfband_mp
    import halfband_pkg::*;
#(
    parameter int NSAMP  = 8,
    parameter int NCOEF  = 3,
    parameter int CWIDTH = HB_CWIDTH_DEF,
    parameter int PIPE   = 3
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [SW*NSAMP-1:0]      s_axis_data_tdata,
    input  logic                     s_axis_data_tvalid,
    output logic [SW*NSAMP-1:0]      m_axis_data_tdata,
    output logic                     m_axis_data_tvalid,
    input  logic                     dec_en,
    input  logic                     coef_wr,
    input  logic [$clog2(NCOEF)-1:0] coef_addr,
    input  logic [CWIDTH-1:0]        coef_data,
    input  logic                     coef_commit
);
    localparam int NTAPS = 4*NCOEF - 1;
    localparam int D     = 2*NCOEF - 1;
    localparam int L     = (D + NSAMP - 1) / NSAMP;
    // Centre beat lags the input by L beats and its oldest tap reaches L beats further back.
    localparam int HB    = 2*L;
    localparam int HALF  = NSAMP / 2;
    localparam int LAST  = PIPE - 2;

    typedef `HB_SAMPLE_VEC(NSAMP) sample_vec_t;
    typedef `HB_SAMPLE_VEC(HALF)  half_vec_t;

    sample_vec_t                     in_vec;
    sample_vec_t                     hist [HB];
    logic [(HB+1)*NSAMP-1:0][SW-1:0] all_s;
    logic [NCOEF-1:0][CWIDTH-1:0]    shadow, active, coef_s1;
    dec_phase_e                      phase;
    logic                            mode, beat_dec;
    ctl_t                            ctl [PIPE-1];
    sample_vec_t                     y_vec;
    half_vec_t                       evens, hold_lo;
    logic                            unused_hist;

    assign in_vec      = sample_vec_t'(s_axis_data_tdata);
    assign unused_hist = ^all_s;

    always_comb begin
        all_s = '0;
        for (int h = 0; h < HB; h++)
            for (int j = 0; j < NSAMP; j++)
                all_s[(HB-1-h)*NSAMP + j] = hist[h][j];
        for (int j = 0; j < NSAMP; j++)
            all_s[HB*NSAMP + j] = in_vec[j];
    end

    // A pair in progress keeps the latched mode; dec_en only matters at phase 0.
    assign beat_dec = (phase == PH_HI) ? mode : dec_en;

    always_ff @(posedge aclk) begin
        if (areset) begin
            phase   <= PH_LO;
            mode    <= 1'b0;
            shadow  <= '0;
            active  <= '0;
            coef_s1 <= '0;
            for (int h = 0; h < HB; h++)
                hist[h] <= '0;
            for (int p = 0; p < PIPE-1; p++)
                ctl[p] <= '0;
        end else begin
            if (s_axis_data_tvalid) begin
                hist[0] <= in_vec;
                for (int h = 1; h < HB; h++)
                    hist[h] <= hist[h-1];
                if (phase == PH_LO)
                    mode <= dec_en;
                phase <= (beat_dec && phase == PH_LO) ? PH_HI : PH_LO;
            end
            ctl[0] <= {s_axis_data_tvalid, beat_dec, phase == PH_HI};
            for (int p = 1; p < PIPE-1; p++)
                ctl[p] <= ctl[p-1];
            if (coef_wr && int'(coef_addr) < NCOEF)
                shadow[coef_addr] <= coef_data;
            if (coef_commit)
                active <= shadow;
            // Bank travels with the beat so the multiply stage sees one consistent set.
            coef_s1 <= active;
        end
    end

    for (genvar i = 0; i < NSAMP; i++) begin : g_lane
        logic [NTAPS-1:0][SW-1:0] win;
        logic [SW-1:0]            y_l;

        always_comb begin
            win = '0;
            for (int t = 0; t < NTAPS; t++)
                win[t] = all_s[(HB-L)*NSAMP + i - D + t];
        end

        halfband_lane #(
            .NCOEF  (NCOEF),
            .CWIDTH (CWIDTH)
        ) u_lane (
            .clk  (aclk),
            .rst  (areset),
            .win  (win),
            .coef (coef_s1),
            .y    (y_l)
        );

        assign y_vec[i] = y_l;
    end

    always_comb begin
        evens = '0;
        for (int j = 0; j < HALF; j++)
            evens[j] = y_vec[2*j];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_data_tvalid <= 1'b0;
            m_axis_data_tdata  <= '0;
            hold_lo            <= '0;
        end else begin
            m_axis_data_tvalid <= 1'b0;
            if (ctl[LAST].v) begin
                if (!ctl[LAST].dec) begin
                    m_axis_data_tdata  <= y_vec;
                    m_axis_data_tvalid <= 1'b1;
                end else if (!ctl[LAST].ph) begin
                    hold_lo <= evens;
                end else begin
                    m_axis_data_tdata  <= {evens, hold_lo};
                    m_axis_data_tvalid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_halfband_mp.sv
// tb/tb_halfband_mp.sv - randomized scoreboard bench for halfband_mp
module tb_halfband_mp;
    localparam int NSAMP  = 8;
    localparam int NCOEF  = 3;
    localparam int CWIDTH = 18;
    localparam int PIPE   = 3;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [127:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic [127:0] m_tdata;
    logic         m_tvalid;
    logic         dec_en = 1'b0;
    logic         coef_wr = 1'b0;
    logic [1:0]   coef_addr = '0;
    logic [17:0]  coef_data = '0;
    logic         coef_commit = 1'b0;

    always #5 aclk = ~aclk;

    halfband_mp #(
        .NSAMP  (NSAMP),
        .NCOEF  (NCOEF),
        .CWIDTH (CWIDTH),
        .PIPE   (PIPE)
    ) dut (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_data_tdata  (s_tdata),
        .s_axis_data_tvalid (s_tvalid),
        .m_axis_data_tdata  (m_tdata),
        .m_axis_data_tvalid (m_tvalid),
        .dec_en             (dec_en),
        .coef_wr            (coef_wr),
        .coef_addr          (coef_addr),
        .coef_data          (coef_data),
        .coef_commit        (coef_commit)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: the sample stream since reset, banks, and the decimation pair state.
    typedef struct {
        logic [127:0] data;
        int           due;
        bit           timed;
    } exp_t;

    int          xs[$];
    int          act[NCOEF];
    int          shd[NCOEF];
    bit          ph = 0;
    bit          md = 0;
    logic [63:0] hold = '0;
    exp_t        expq[$];
    exp_t        mon_e;

    function automatic int sx18(input int v);
        logic [17:0] t;
        t = 18'(v);
        return int'($signed(t));
    endfunction

    function automatic int xv(input int n);
        if (n < 0 || n >= xs.size())
            return 0;
        return xs[n];
    endfunction

    function automatic int ymodel(input int n);
        longint acc;
        acc = longint'(xv(n)) * 65536;
        for (int k = 0; k < NCOEF; k++)
            acc += longint'(act[k]) * longint'(xv(n - 2*k - 1) + xv(n + 2*k + 1));
        acc = (acc + 65536) >>> 17;
        if (acc > 32767)
            return 32767;
        if (acc < -32768)
            return -32768;
        return int'(acc);
    endfunction

    task automatic model_beat(input logic [127:0] d, input bit de);
        logic [127:0] y;
        logic [63:0]  ev;
        int           base;
        bit           eff;
        exp_t         e;
        for (int i = 0; i < NSAMP; i++)
            xs.push_back(int'($signed(d[16*i +: 16])));
        base = xs.size() - 2*NSAMP;
        for (int i = 0; i < NSAMP; i++)
            y[16*i +: 16] = 16'(ymodel(base + i));
        for (int j = 0; j < NSAMP/2; j++)
            ev[16*j +: 16] = y[32*j +: 16];
        if (!ph)
            md = de;
        eff = ph ? md : de;
        if (!eff) begin
            e.data  = y;
            e.due   = cyc + PIPE;
            e.timed = 1;
            expq.push_back(e);
        end else if (!ph) begin
            hold = ev;
            ph   = 1;
        end else begin
            e.data  = {ev, hold};
            e.due   = 0;
            e.timed = 0;
            expq.push_back(e);
            ph = 0;
        end
    endtask

    task automatic step(input bit v, input logic [127:0] d, input bit de, input bit wr,
                        input int addr, input int cd, input bit cm);
        s_tvalid    = v;
        s_tdata     = d;
        dec_en      = de;
        coef_wr     = wr;
        coef_addr   = 2'(addr);
        coef_data   = 18'(cd);
        coef_commit = cm;
        if (v)
            model_beat(d, de);
        if (cm)
            for (int k = 0; k < NCOEF; k++)
                act[k] = shd[k];
        if (wr)
            shd[addr] = sx18(cd);
        @(posedge aclk);
        #1;
    endtask

    task automatic beat(input logic [127:0] d, input bit de);
        step(1, d, de, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(0, {4{$urandom}}, 0, 0, 0, 0, 0);
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2);
        step(0, '0, 0, 1, 0, c0, 0);
        step(0, '0, 0, 1, 1, c1, 0);
        step(0, '0, 0, 1, 2, c2, 0);
        step(0, '0, 0, 0, 0, 0, 1);
    endtask

    function automatic logic [127:0] ramp(input int b);
        logic [127:0] d;
        for (int i = 0; i < NSAMP; i++)
            d[16*i +: 16] = 16'(b*NSAMP + i);
        return d;
    endfunction

    task automatic do_reset();
        idle(PIPE + 2);
        chk("drain_before_reset", 128'(expq.size()), 0);
        areset      = 1'b1;
        s_tvalid    = 1'b0;
        coef_wr     = 1'b0;
        coef_commit = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        xs.delete();
        expq.delete();
        for (int k = 0; k < NCOEF; k++) begin
            act[k] = 0;
            shd[k] = 0;
        end
        ph   = 0;
        md   = 0;
        hold = '0;
        chk("reset_tvalid", 128'(m_tvalid), 0);
        chk("reset_tdata", m_tdata, 0);
    endtask

    always @(negedge aclk) begin
        if (!areset && m_tvalid === 1'b1) begin
            if (expq.size() == 0) begin
                chk("spurious_tvalid", 1, 0);
            end else begin
                mon_e = expq.pop_front();
                chk("out_data", m_tdata, mon_e.data);
                if (mon_e.timed)
                    chk("out_latency", 128'(cyc), 128'(mon_e.due));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        bit           rdec;
        for (int k = 0; k < NCOEF; k++) begin
            act[k] = 0;
            shd[k] = 0;
        end
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        chk("reset_tvalid", 128'(m_tvalid), 0);
        chk("reset_tdata", m_tdata, 0);

        repeat (4) beat('0, 0);

        beat(128'd1000, 0);
        repeat (3) beat('0, 0);

        set_coefs(32'h10000, 0, 0);
        beat(128'd1000, 0);
        repeat (3) beat('0, 0);

        set_coefs(32'h1FFFF, 32'h1FFFF, 32'h1FFFF);
        repeat (4) beat({8{16'h7fff}}, 0);
        repeat (4) beat({8{16'h8000}}, 0);

        // Shadow write and commit in the same cycle: commit takes the pre-write value.
        step(0, '0, 0, 1, 1, 32'h00400, 1);
        repeat (3) beat({4{$urandom}}, 0);
        step(0, '0, 0, 0, 0, 0, 1);
        repeat (3) beat({4{$urandom}}, 0);

        do_reset();
        begin
            bit des [8] = '{1, 1, 1, 0, 0, 1, 1, 0};
            for (int b = 0; b < 8; b++)
                beat(ramp(b), des[b]);
            for (int b = 8; b < 16; b++) begin
                beat(ramp(b), 1);
                idle($urandom_range(0, 2));
            end
        end

        // Reset with a half-filled decimation pair outstanding.
        beat(ramp(16), 1);
        do_reset();
        beat(ramp(1), 1);
        beat(ramp(2), 1);
        beat(ramp(3), 0);

        rdec = 0;
        for (int b = 0; b < 400; b++) begin
            for (int i = 0; i < NSAMP; i++)
                d[16*i +: 16] = 16'($urandom);
            if ($urandom_range(0, 19) == 0)
                rdec = ~rdec;
            step(1, d, rdec, $urandom_range(0, 3) == 0, $urandom_range(0, 2),
                 int'($urandom), $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 3))
                step(0, {4{$urandom}}, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2), int'($urandom), $urandom_range(0, 7) == 0);
        end

        idle(PIPE + 3);
        chk("final_drain", 128'(expq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
